cb_result_arbiter: RTL and testbench
====================================

Name: cb_result_arbiter

Overview:
- Arbitrates functional-unit results into the completion buffer's limited result-write ports.
- Sources, fixed order: 0=arith (a), 1=multiply (mu), 2=divide (du), 3=load/store (ls), 4=vector scalar writeback (v).
- Grants up to WPORTS results per cycle with rotating round-robin priority and back-pressures the ungranted units.
- Registers granted results for one cycle before the completion-buffer write. Also provides a duplicate-index error flag and a stall counter.

Parameters:
NUM, 16, completion-buffer depth; IDXW = $clog2(NUM)
NSRC, 5, number of result sources (order above)
WPORTS, 2, completion-buffer result write ports per cycle; legal 1..NSRC
CNTW, 16, stall counter width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
flush  in  1  pipeline flush from hazard unit
req_valid  in  NSRC  source i has a result
req_index  in  NSRC*IDXW  completion-buffer entry index, source i
req_vd  in  NSRC*5  destination register, source i
req_wdata  in  NSRC*32  result word_t, source i
req_exc  in  NSRC  result raised an exception
req_ready  out  NSRC  grant/accept to source i
wr_en  out  WPORTS  write port p valid
wr_index  out  WPORTS*IDXW  entry index, port p
wr_vd  out  WPORTS*5  destination register, port p
wr_wdata  out  WPORTS*32  result, port p
wr_exc  out  WPORTS  exception bit, port p
err_dup_index  out  1  sticky: two same-cycle grants carried the same index
stall_cnt  out  CNTW  saturating count of cycles with at least one ungranted valid source

Behaviour:
- Reset (nRST=0, asynchronous):
  - rr_ptr=0, wr_en=0, wr_index/vd/wdata/exc=0.
  - err_dup_index=0, stall_cnt=0.
  - req_ready is combinational but forced 0 while nRST=0.
- Handshake: a source holds valid and its payload stable until it sees req_valid&req_ready on a rising edge. Payload changes while waiting are illegal.
- Grant (combinational):
  - Scan sources rr_ptr, rr_ptr+1, … mod NSRC.
  - The first WPORTS sources with req_valid=1 are granted.
  - The k-th granted source in scan order maps to port k.
  - req_ready[i] = grant[i] & ~flush.
- rr_ptr update: on any grant, rr_ptr <= (index of last granted source + 1) mod NSRC. With no grant, it is unchanged.
- Output register:
  - Each edge, wr_en[p] <= port p assigned & ~flush; the payload of the granted source is captured.
  - Unassigned ports capture wr_en=0 and keep their previous payload.
  - Latency is exactly 1 cycle from accepted handshake to wr_en.
- Flush:
  - Combinational: req_ready=0 and the outputs present wr_en = wr_en_q & ~flush, so a registered result is discarded in the flush cycle.
  - At the next edge, wr_en_q <= 0 and rr_ptr is unchanged.
  - Sources keep valid; upstream units drop their own results on flush.
- Full throughput: with all sources valid, each source is granted at least once every ceil(NSRC/WPORTS) cycles (3 for defaults). There is no starvation.
- err_dup_index: set when two granted sources in the same cycle have equal req_index. It stays set until reset and does not block grants.
- stall_cnt: increments when (req_valid & ~req_ready) != 0 and flush=0. It saturates at all-ones.
- WPORTS >= count of valid sources: all valid sources are granted in the same cycle.

Decomposition:
- In rv32i_types_pkg (or a cb package):
  - cb_result_t struct {index, vd, wdata, exc}
  - source enum CB_SRC_A..CB_SRC_V
  - NSRC constant
- Sub-module rr_multi_grant: combinational scan of valid + ptr, producing a grant vector and a per-port source-index array. It is parameterised on N and WPORTS and reusable for other schedulers.
- Top level holds rr_ptr, output registers, the error flag and the counter.

Test Plan:
- Reset then idle: after nRST release, all outputs are 0 and req_ready=0 with no valids.
- Single source: req_valid[3]=1, index=5, vd=7, wdata=0xDEADBEEF, exc=0.
  - Same cycle: req_ready[3]=1.
  - Next cycle: wr_en=2'b01, wr_index[0]=5, wr_vd[0]=7, wr_wdata[0]=0xDEADBEEF.
- All five valid and held continuously from rr_ptr=0:
  - Grant sequence {0,1}, {2,3}, {4,0}, {1,2}.
  - stall_cnt increments every cycle; each source is granted within 3 cycles.
- Flush: grant source 1 at cycle t, assert flush at t+1.
  - wr_en reads 0 at t+1 and t+2.
  - req_ready=0 during flush; rr_ptr is retained.
- Duplicate index: sources 0 and 2 valid with index=9 in the same cycle.
  - Both are granted; err_dup_index=1 from the next cycle onward, persisting until nRST.
- Reset mid-operation: assert nRST=0 with wr_en=2'b11 and stall_cnt=0x0010.
  - All outputs drop to 0 immediately, without waiting for a clock edge.
  - stall_cnt saturation check: preload near all-ones by running stalled for a long time, and confirm it holds at 0xFFFF.

Source files
------------

// File: rtl/cb_result_arbiter_pkg.sv
// Shared types and defaults for the completion-buffer result arbiter.
// Source order is fixed: arith, multiply, divide, load/store, vector writeback.
package cb_result_arbiter_pkg;

  localparam int CB_NUM    = 16;
  localparam int CB_IDXW   = $clog2(CB_NUM);
  localparam int CB_NSRC   = 5;
  localparam int CB_WPORTS = 2;
  localparam int CB_CNTW   = 16;

  typedef enum logic [2:0] {
    CB_SRC_A  = 3'd0,
    CB_SRC_MU = 3'd1,
    CB_SRC_DU = 3'd2,
    CB_SRC_LS = 3'd3,
    CB_SRC_V  = 3'd4
  } cb_src_e;

  typedef struct packed {
    logic [CB_IDXW-1:0] index;
    logic [4:0]         vd;
    logic [31:0]        wdata;
    logic               exc;
  } cb_result_t;

  // Single conditional subtract; callers guarantee i < 2*n.
  function automatic int cb_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/cb_result_arbiter_if.sv
// Result-request and completion-buffer write bundle of the result arbiter.
// master = functional-unit / completion-buffer side, slave = arbiter.
interface cb_result_arbiter_if
  import cb_result_arbiter_pkg::*;
#(
    parameter int NUM    = CB_NUM,
    parameter int NSRC   = CB_NSRC,
    parameter int WPORTS = CB_WPORTS,
    parameter int CNTW   = CB_CNTW
);
    localparam int IDXW = $clog2(NUM);

    logic [NSRC-1:0]        req_valid;
    logic [NSRC*IDXW-1:0]   req_index;
    logic [NSRC*5-1:0]      req_vd;
    logic [NSRC*32-1:0]     req_wdata;
    logic [NSRC-1:0]        req_exc;
    logic [NSRC-1:0]        req_ready;

    logic [WPORTS-1:0]      wr_en;
    logic [WPORTS*IDXW-1:0] wr_index;
    logic [WPORTS*5-1:0]    wr_vd;
    logic [WPORTS*32-1:0]   wr_wdata;
    logic [WPORTS-1:0]      wr_exc;

    logic                   err_dup_index;
    logic [CNTW-1:0]        stall_cnt;

    modport master (
        output req_valid, req_index, req_vd, req_wdata, req_exc,
        input  req_ready, wr_en, wr_index, wr_vd, wr_wdata, wr_exc,
        input  err_dup_index, stall_cnt
    );

    modport slave (
        input  req_valid, req_index, req_vd, req_wdata, req_exc,
        output req_ready, wr_en, wr_index, wr_vd, wr_wdata, wr_exc,
        output err_dup_index, stall_cnt
    );
endinterface

// File: rtl/cb_result_arbiter_rr_multi_grant.sv
// Combinational multi-grant round-robin scan: from i_ptr upward (mod N) the first
// WPORTS valid requesters are granted; the k-th grant in scan order lands on port k.
module rr_multi_grant
  import cb_result_arbiter_pkg::*;
#(
    parameter  int N      = CB_NSRC,
    parameter  int WPORTS = CB_WPORTS,
    localparam int PW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      i_valid,
    input  logic [PW-1:0]     i_ptr,
    output logic [N-1:0]      o_grant,
    output logic [WPORTS-1:0] o_port_vld,
    output logic [PW-1:0]     o_port_src [WPORTS],
    output logic [PW-1:0]     o_last
);
    int w_cnt;
    int w_idx;

    always_comb begin
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        o_grant    = '0;
        o_port_vld = '0;
        o_last     = '0;
        for (int p = 0; p < WPORTS; p++) o_port_src[p] = '0;
        w_cnt = 0;
        w_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = cb_wrap(int'(i_ptr) + k, N);
            for (int s = 0; s < N; s++) begin
                if (s == w_idx && i_valid[s] && w_cnt < WPORTS) begin
                    o_grant[s] = 1'b1;
                    for (int p = 0; p < WPORTS; p++) begin
                        if (p == w_cnt) begin
                            o_port_vld[p] = 1'b1;
                            o_port_src[p] = PW'(s);
                        end
                    end
                    o_last = PW'(s);
                    w_cnt  = w_cnt + 1;
                end
            end
        end
    end
endmodule

// File: rtl/cb_result_arbiter.sv
// Routes up to WPORTS functional-unit results per cycle into the completion buffer,
// registering them one cycle; tracks duplicate-index grants and stalled cycles.
module cb_result_arbiter
  import cb_result_arbiter_pkg::*;
#(
    parameter int NUM    = CB_NUM,
    parameter int NSRC   = CB_NSRC,
    parameter int WPORTS = CB_WPORTS,
    parameter int CNTW   = CB_CNTW
) (
    input logic              CLK,
    input logic              nRST,
    input logic              flush,
    cb_result_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NUM);
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef struct packed {
        logic [IDXW-1:0] index;
        logic [4:0]      vd;
        logic [31:0]     wdata;
        logic            exc;
    } res_t;

    res_t              w_src      [NSRC];
    res_t              w_port     [WPORTS];
    res_t              r_port     [WPORTS];
    logic [NSRC-1:0]   w_grant;
    logic [WPORTS-1:0] w_port_vld;
    logic [SW-1:0]     w_port_src [WPORTS];
    logic [SW-1:0]     w_last;
    logic              w_dup;
    logic              w_stall;
    logic [SW-1:0]     r_rr_ptr;
    logic [WPORTS-1:0] r_wr_en;
    logic              r_err_dup;
    logic [CNTW-1:0]   r_stall_cnt;

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            w_src[s].index = bus.req_index[s*IDXW +: IDXW];
            w_src[s].vd    = bus.req_vd[s*5 +: 5];
            w_src[s].wdata = bus.req_wdata[s*32 +: 32];
            w_src[s].exc   = bus.req_exc[s];
        end
    end

    rr_multi_grant #(.N(NSRC), .WPORTS(WPORTS)) u_grant (
        .i_valid    (bus.req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_port_vld (w_port_vld),
        .o_port_src (w_port_src),
        .o_last     (w_last)
    );

    always_comb begin
        w_dup = 1'b0;
        for (int p = 0; p < WPORTS; p++) begin
            w_port[p] = '0;
            for (int s = 0; s < NSRC; s++)
                if (s == int'(w_port_src[p])) w_port[p] = w_src[s];
        end
        for (int p = 0; p < WPORTS; p++)
            for (int q = p + 1; q < WPORTS; q++)
                if (w_port_vld[p] && w_port_vld[q] && w_port[p].index == w_port[q].index)
                    w_dup = 1'b1;
    end

    // Ready is held low throughout reset even though it is purely combinational.
    assign bus.req_ready = nRST ? (w_grant & ~{NSRC{flush}}) : '0;
    assign w_stall       = |(bus.req_valid & ~bus.req_ready);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr    <= '0;
            r_wr_en     <= '0;
            r_err_dup   <= 1'b0;
            r_stall_cnt <= '0;
            // NOTE: the port payload registers are a handful of flops with defined reset values, not a RAM, so they are reset.
            for (int p = 0; p < WPORTS; p++) r_port[p] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            r_wr_en <= w_port_vld & ~{WPORTS{flush}};
            for (int p = 0; p < WPORTS; p++)
                if (w_port_vld[p] && !flush) r_port[p] <= w_port[p];
            if (!flush && |w_grant)
                r_rr_ptr <= (int'(w_last) == NSRC - 1) ? '0 : w_last + SW'(1);
            if (!flush && w_dup)
                r_err_dup <= 1'b1;
            if (!flush && w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    // A result registered last cycle is discarded if flush arrives while it is presented.
    assign bus.wr_en         = r_wr_en & ~{WPORTS{flush}};
    assign bus.err_dup_index = r_err_dup;
    assign bus.stall_cnt     = r_stall_cnt;

    for (genvar g = 0; g < WPORTS; g++) begin : g_wr
        assign bus.wr_index[g*IDXW +: IDXW] = r_port[g].index;
        assign bus.wr_vd[g*5 +: 5]          = r_port[g].vd;
        assign bus.wr_wdata[g*32 +: 32]     = r_port[g].wdata;
        assign bus.wr_exc[g]                = r_port[g].exc;
    end
endmodule

// File: tb/tb_cb_result_arbiter.sv
// Self-checking bench for cb_result_arbiter: table vectors plus hand sequences,
// with a reference round-robin model feeding a one-deep expected-output queue.
module tb_cb_result_arbiter;
    import cb_result_arbiter_pkg::*;

    localparam int NSRC   = CB_NSRC;
    localparam int WPORTS = CB_WPORTS;
    localparam int IDXW   = CB_IDXW;
    localparam int CNTW   = CB_CNTW;

    typedef struct packed {
        logic [NSRC-1:0] valid;
        logic [NSRC-1:0] exp_ready;
    } vec_t;

    typedef struct packed {
        logic [WPORTS-1:0]            en;
        cb_result_t [WPORTS-1:0]      res;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    cb_result_t      src_pl [NSRC];
    cb_result_t      m_port [WPORTS];
    int              m_ptr;
    logic [CNTW-1:0] m_stall;
    logic            m_err;
    exp_t            sb_q [$];

    always #5 clk = ~clk;

    cb_result_arbiter_if #(.NUM(CB_NUM), .NSRC(NSRC), .WPORTS(WPORTS), .CNTW(CNTW)) bus ();

    cb_result_arbiter #(.NUM(CB_NUM), .NSRC(NSRC), .WPORTS(WPORTS), .CNTW(CNTW)) dut (
        .CLK   (clk),
        .nRST  (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [NSRC-1:0] v, input logic f);
        bus.req_valid = v;
        flush         = f;
        for (int s = 0; s < NSRC; s++) begin
            bus.req_index[s*IDXW +: IDXW] = src_pl[s].index;
            bus.req_vd[s*5 +: 5]          = src_pl[s].vd;
            bus.req_wdata[s*32 +: 32]     = src_pl[s].wdata;
            bus.req_exc[s]                = src_pl[s].exc;
        end
    endtask

    task automatic init_payload();
        for (int s = 0; s < NSRC; s++) begin
            src_pl[s].index = IDXW'(2 * s + 1);
            src_pl[s].vd    = 5'(s + 20);
            src_pl[s].wdata = 32'hA000_0000 | 32'(s * 32'h111);
            src_pl[s].exc   = s[0];
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_stall = '0;
        m_err   = 1'b0;
        for (int p = 0; p < WPORTS; p++) m_port[p] = '0;
        sb_q.delete();
    endtask

    // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
    task automatic step(input string tag);
        logic [NSRC-1:0] g;
        int              psrc [WPORTS];
        int              np;
        int              last;
        int              s;
        exp_t            e;
        exp_t            o;
        logic            dup;
        #1;
        if (sb_q.size() > 0) begin
            o = sb_q.pop_front();
            check({tag, ".wr_en"}, 64'(bus.wr_en), 64'(o.en & ~{WPORTS{flush}}));
            for (int p = 0; p < WPORTS; p++) begin
                if (o.en[p] && !flush) begin
                    check({tag, ".wr_index"}, 64'(bus.wr_index[p*IDXW +: IDXW]), 64'(o.res[p].index));
                    check({tag, ".wr_vd"},    64'(bus.wr_vd[p*5 +: 5]),          64'(o.res[p].vd));
                    check({tag, ".wr_wdata"}, 64'(bus.wr_wdata[p*32 +: 32]),     64'(o.res[p].wdata));
                    check({tag, ".wr_exc"},   64'(bus.wr_exc[p]),                64'(o.res[p].exc));
                end
            end
        end
        check({tag, ".err_dup"}, 64'(bus.err_dup_index), 64'(m_err));
        check({tag, ".stall"},   64'(bus.stall_cnt),     64'(m_stall));

        g    = '0;
        np   = 0;
        last = m_ptr;
        for (int k = 0; k < NSRC; k++) begin
            s = (m_ptr + k) % NSRC;
            if (bus.req_valid[s] && np < WPORTS) begin
                g[s]     = 1'b1;
                psrc[np] = s;
                np++;
                last     = s;
            end
        end
        check({tag, ".ready"}, 64'(bus.req_ready), 64'(flush ? '0 : g));

        e.en = '0;
        dup  = 1'b0;
        if (!flush) begin
            for (int p = 0; p < np; p++) begin
                e.en[p]   = 1'b1;
                m_port[p] = src_pl[psrc[p]];
                for (int q = p + 1; q < np; q++)
                    if (src_pl[psrc[p]].index == src_pl[psrc[q]].index) dup = 1'b1;
            end
            if ((bus.req_valid & ~g) != '0 && m_stall != '1) m_stall = m_stall + 1'b1;
            if (np > 0) m_ptr = (last + 1) % NSRC;
            m_err = m_err | dup;
        end
        for (int p = 0; p < WPORTS; p++) e.res[p] = m_port[p];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            tbl [7];
        logic [NSRC-1:0] rr_seq [6];
        int              gcnt [NSRC];

        tbl[0] = '{valid: 5'b00011, exp_ready: 5'b00011};
        tbl[1] = '{valid: 5'b10101, exp_ready: 5'b10100};
        tbl[2] = '{valid: 5'b01001, exp_ready: 5'b01001};
        tbl[3] = '{valid: 5'b11110, exp_ready: 5'b10010};
        tbl[4] = '{valid: 5'b01100, exp_ready: 5'b01100};
        tbl[5] = '{valid: 5'b00100, exp_ready: 5'b00100};
        tbl[6] = '{valid: 5'b00000, exp_ready: 5'b00000};
        rr_seq[0] = 5'b00011; rr_seq[1] = 5'b01100; rr_seq[2] = 5'b10001;
        rr_seq[3] = 5'b00110; rr_seq[4] = 5'b11000; rr_seq[5] = 5'b00011;

        // Reset: ready forced low even with every source requesting.
        init_payload();
        model_reset();
        apply('1, 1'b0);
        #2;
        check("rst.ready_forced", 64'(bus.req_ready), 64'(0));
        check("rst.wr_en", 64'(bus.wr_en), 64'(0));
        apply('0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle.wr_en",    64'(bus.wr_en),         64'(0));
        check("idle.wr_index", 64'(bus.wr_index),      64'(0));
        check("idle.wr_vd",    64'(bus.wr_vd),         64'(0));
        check("idle.wr_wdata", 64'(bus.wr_wdata),      64'(0));
        check("idle.wr_exc",   64'(bus.wr_exc),        64'(0));
        check("idle.err",      64'(bus.err_dup_index), 64'(0));
        check("idle.stall",    64'(bus.stall_cnt),     64'(0));
        check("idle.ready",    64'(bus.req_ready),     64'(0));

        // Single load/store result.
        src_pl[int'(CB_SRC_LS)] = '{index: 4'd5, vd: 5'd7, wdata: 32'hDEAD_BEEF, exc: 1'b0};
        apply(5'b01000, 1'b0);
        #1;
        check("single.ready", 64'(bus.req_ready), 64'(5'b01000));
        step("single");
        check("single.wr_en",    64'(bus.wr_en),           64'(2'b01));
        check("single.wr_index", 64'(bus.wr_index[3:0]),   64'(5));
        check("single.wr_vd",    64'(bus.wr_vd[4:0]),      64'(7));
        check("single.wr_wdata", 64'(bus.wr_wdata[31:0]),  64'h0000_0000_DEAD_BEEF);
        apply('0, 1'b0);
        step("single_drain");

        // Table vectors starting from rr_ptr = 4.
        init_payload();
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].valid, 1'b0);
            #1;
            check($sformatf("tbl%0d.ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            step($sformatf("tbl%0d", i));
        end

        // Park rr_ptr at 0, then hold all five sources valid.
        apply(5'b10000, 1'b0);
        step("park");
        for (int s = 0; s < NSRC; s++) gcnt[s] = 0;
        for (int c = 0; c < 6; c++) begin
            apply('1, 1'b0);
            #1;
            check($sformatf("rr%0d.ready", c), 64'(bus.req_ready), 64'(rr_seq[c]));
            for (int s = 0; s < NSRC; s++) if (bus.req_ready[s]) gcnt[s]++;
            step($sformatf("rr%0d", c));
        end
        for (int s = 0; s < NSRC; s++)
            check($sformatf("rr.src%0d_grants_ge2", s), 64'(gcnt[s] >= 2), 64'(1));
        apply('0, 1'b0);
        step("rr_drain");

        // Flush: grant source 1, flush next cycle, confirm pointer is retained.
        apply(5'b00010, 1'b0);
        step("fl_t");
        apply(5'b01000, 1'b1);
        #1;
        check("fl_t1.wr_en", 64'(bus.wr_en),     64'(0));
        check("fl_t1.ready", 64'(bus.req_ready), 64'(0));
        step("fl_t1");
        apply(5'b01110, 1'b0);
        #1;
        check("fl_t2.wr_en", 64'(bus.wr_en),     64'(0));
        check("fl_t2.ready", 64'(bus.req_ready), 64'(5'b01100));
        step("fl_t2");
        apply(5'b00010, 1'b0);
        step("fl_t3");
        apply('0, 1'b0);
        step("fl_drain");

        // Duplicate index on sources 0 and 2.
        src_pl[0].index = 4'd9;
        src_pl[2].index = 4'd9;
        apply(5'b00101, 1'b0);
        #1;
        check("dup.ready", 64'(bus.req_ready), 64'(5'b00101));
        step("dup");
        check("dup.err_set", 64'(bus.err_dup_index), 64'(1));
        init_payload();
        apply('0, 1'b0);
        for (int c = 0; c < 3; c++) step($sformatf("dup_hold%0d", c));

        // Build stall_cnt to 0x10 with both ports busy, then reset asynchronously.
        do begin
            apply('1, 1'b0);
            step("build");
        end while (m_stall < 16);
        check("prerst.wr_en", 64'(bus.wr_en),     64'(2'b11));
        check("prerst.stall", 64'(bus.stall_cnt), 64'h10);
        rst_n = 1'b0;
        #1;
        check("asyncrst.wr_en",    64'(bus.wr_en),         64'(0));
        check("asyncrst.wr_wdata", 64'(bus.wr_wdata),      64'(0));
        check("asyncrst.stall",    64'(bus.stall_cnt),     64'(0));
        check("asyncrst.err",      64'(bus.err_dup_index), 64'(0));
        check("asyncrst.ready",    64'(bus.req_ready),     64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: every edge from here on counts one stalled cycle.
        apply('1, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat.fffe", 64'(bus.stall_cnt), 64'hFFFE);
        @(posedge clk);
        #1;
        check("sat.ffff", 64'(bus.stall_cnt), 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat.hold", 64'(bus.stall_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
